// File: rtl/cisr_row_decoder.sv
// cisr_row_decoder: central CISR row-ID assigner for the SpMV channels.
// It pops row lengths from each channel's row FIFO, hands out global row IDs
// lowest channel first, and tags every fetched nonzero with its row ID.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   num_rows       - total matrix rows, latched on the first cycle out of reset
//   len_valid      - per-channel row FIFO non-empty
//   row_len_in     - per-channel FIFO head, channel c at [c*DATA_W +: DATA_W]
//   slot_valid     - per-channel nonzero fetched this cycle
//   len_pop        - per-channel FIFO pop (combinational)
//   row_id_out     - per-channel row ID of the previous cycle's nonzero
//   ch_busy        - per-channel RUN indicator
//   done           - all rows assigned and every channel finished (sticky)
//   proto_err      - sticky: slot_valid seen on a channel not in RUN
module cisr_row_decoder #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIM_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DIM_W:0]           num_rows,
  input  logic [NUM_CH-1:0]        len_valid,
  input  logic [NUM_CH*DATA_W-1:0] row_len_in,
  input  logic [NUM_CH-1:0]        slot_valid,
  output logic [NUM_CH-1:0]        len_pop,
  output logic [NUM_CH*DIM_W-1:0]  row_id_out,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic                     done,
  output logic                     proto_err
);

  localparam int unsigned CNT_W = DIM_W + 1;

  typedef enum logic [1:0] {
    ST_NEED = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } ch_state_e;

  // Registered state
  logic              started_q;
  logic [CNT_W-1:0]  rows_q;
  logic [CNT_W-1:0]  next_row_q;
  logic              done_q;
  logic              proto_err_q;
  ch_state_e         st_q     [NUM_CH];
  logic [DATA_W-1:0] rem_q    [NUM_CH];
  logic [DIM_W-1:0]  cur_id_q [NUM_CH];
  logic [DIM_W-1:0]  row_id_q [NUM_CH];

  // Next-state values
  logic [CNT_W-1:0]  next_row_d;
  logic              done_d;
  logic              proto_err_d;
  ch_state_e         st_d     [NUM_CH];
  logic [DATA_W-1:0] rem_d    [NUM_CH];
  logic [DIM_W-1:0]  cur_id_d [NUM_CH];
  logic [DIM_W-1:0]  row_id_d [NUM_CH];

  // Grant network
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic [DIM_W-1:0]  grant_id [NUM_CH];
  logic [CNT_W-1:0]  id_acc;
  logic              rows_exhausted;
  logic              all_fin;

  // Ascending-priority grant: each granted requester takes the next free ID
  // until the row budget runs out. Nothing is granted in the latch cycle.
  always_comb begin
    req    = '0;
    grant  = '0;
    id_acc = next_row_q;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      grant_id[c] = '0;
    end
    for (int c = 0; c < int'(NUM_CH); c++) begin
      req[c] = started_q && len_valid[c] &&
               ((st_q[c] == ST_NEED) ||
                ((st_q[c] == ST_RUN) && (rem_q[c] == DATA_W'(1)) && slot_valid[c]));
      if (req[c] && (id_acc < rows_q)) begin
        grant[c]    = 1'b1;
        grant_id[c] = id_acc[DIM_W-1:0];
        id_acc      = id_acc + CNT_W'(1);
      end
    end
    next_row_d = id_acc;
  end

  // Per-channel next state, protocol check and completion detect
  always_comb begin
    proto_err_d    = proto_err_q;
    rows_exhausted = (next_row_d >= rows_q);
    all_fin        = 1'b1;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      st_d[c]     = st_q[c];
      rem_d[c]    = rem_q[c];
      cur_id_d[c] = cur_id_q[c];
      row_id_d[c] = row_id_q[c];

      if (slot_valid[c] && (st_q[c] != ST_RUN)) begin
        proto_err_d = 1'b1;
      end

      // A grant loads the popped length; a zero-length row just burns its ID.
      if (grant[c]) begin
        if (row_len_in[c*DATA_W +: DATA_W] != '0) begin
          rem_d[c]    = row_len_in[c*DATA_W +: DATA_W];
          cur_id_d[c] = grant_id[c];
          st_d[c]     = ST_RUN;
        end else begin
          rem_d[c] = '0;
          st_d[c]  = ST_NEED;
        end
      end

      case (st_q[c])
        ST_NEED: begin
          if (!grant[c] && started_q && rows_exhausted) begin
            st_d[c] = ST_FIN;
          end
        end
        ST_RUN: begin
          if (slot_valid[c]) begin
            // Tag with the row being drained, even when a refill lands now.
            row_id_d[c] = cur_id_q[c];
            if (rem_q[c] == DATA_W'(1)) begin
              if (!grant[c]) begin
                st_d[c] = rows_exhausted ? ST_FIN : ST_NEED;
              end
            end else begin
              rem_d[c] = rem_q[c] - DATA_W'(1);
            end
          end
        end
        ST_FIN: begin
          st_d[c] = ST_FIN;
        end
        default: begin
          st_d[c] = ST_NEED;
        end
      endcase

      if (st_d[c] != ST_FIN) begin
        all_fin = 1'b0;
      end
    end
    // Raised together with the last channel entering FIN.
    done_d = done_q | (started_q && all_fin && (next_row_d == rows_q));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      started_q   <= 1'b0;
      rows_q      <= '0;
      next_row_q  <= '0;
      done_q      <= 1'b0;
      proto_err_q <= 1'b0;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        st_q[c]     <= ST_NEED;
        rem_q[c]    <= '0;
        cur_id_q[c] <= '0;
        row_id_q[c] <= '0;
      end
    end else begin
      started_q <= 1'b1;
      if (!started_q) begin
        rows_q <= num_rows;
      end
      next_row_q  <= next_row_d;
      done_q      <= done_d;
      proto_err_q <= proto_err_d;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        st_q[c]     <= st_d[c];
        rem_q[c]    <= rem_d[c];
        cur_id_q[c] <= cur_id_d[c];
        row_id_q[c] <= row_id_d[c];
      end
    end
  end

  // Output mapping
  always_comb begin
    len_pop    = grant;
    row_id_out = '0;
    ch_busy    = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      row_id_out[c*DIM_W +: DIM_W] = row_id_q[c];
      ch_busy[c]                   = (st_q[c] == ST_RUN);
    end
  end

  assign done      = done_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cisr_row_decoder.sv
// tb_cisr_row_decoder: directed bench for cisr_row_decoder with 4 channels.
// The bench models each channel's row FIFO as a small array so pops are
// honoured, and checks outputs #1 after the rising edge.
module tb_cisr_row_decoder;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIM_W  = 8;

  logic                     clk;
  logic                     reset;
  logic [DIM_W:0]           num_rows;
  logic [NUM_CH-1:0]        len_valid;
  logic [NUM_CH*DATA_W-1:0] row_len_in;
  logic [NUM_CH-1:0]        slot_valid;
  logic [NUM_CH-1:0]        len_pop;
  logic [NUM_CH*DIM_W-1:0]  row_id_out;
  logic [NUM_CH-1:0]        ch_busy;
  logic                     done;
  logic                     proto_err;

  int n_cmp = 0;
  int n_mis = 0;

  logic [DATA_W-1:0] fmem [NUM_CH][8];
  int rd [NUM_CH];
  int wr [NUM_CH];

  cisr_row_decoder #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .DIM_W (DIM_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .num_rows  (num_rows),
    .len_valid (len_valid),
    .row_len_in(row_len_in),
    .slot_valid(slot_valid),
    .len_pop   (len_pop),
    .row_id_out(row_id_out),
    .ch_busy   (ch_busy),
    .done      (done),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int c = 0; c < int'(NUM_CH); c++) begin
      len_valid[c] = (rd[c] != wr[c]);
      row_len_in[c*DATA_W +: DATA_W] = (rd[c] != wr[c]) ? fmem[c][rd[c]] : '0;
    end
  endtask

  task automatic push(input int c, input logic [DATA_W-1:0] len);
    fmem[c][wr[c]] = len;
    wr[c]++;
  endtask

  // Advance one clock; FIFO entries popped at the edge are removed.
  task automatic tick();
    logic [NUM_CH-1:0] pop;
    #1;
    pop = len_pop;
    @(posedge clk);
    #1;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (pop[c]) rd[c]++;
    end
    refresh();
  endtask

  // One reset edge, empty FIFOs, new row count; caller then releases reset.
  task automatic start_seg(input logic [DIM_W:0] rows);
    reset      = 1'b1;
    slot_valid = '0;
    tick();
    for (int c = 0; c < int'(NUM_CH); c++) begin
      rd[c] = 0;
      wr[c] = 0;
    end
    num_rows = rows;
    refresh();
  endtask

  initial begin
    reset      = 1'b1;
    num_rows   = '0;
    slot_valid = '0;
    len_valid  = '0;
    row_len_in = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      rd[c] = 0;
      wr[c] = 0;
    end
    tick();
    tick();

    // Reset state
    chk("rst_len_pop",   64'(len_pop),    64'h0);
    chk("rst_row_id",    64'(row_id_out), 64'h0);
    chk("rst_busy",      64'(ch_busy),    64'h0);
    chk("rst_done",      64'(done),       64'h0);
    chk("rst_proto_err", 64'(proto_err),  64'h0);

    // Initial grants, single slot
    start_seg(9'd4);
    for (int c = 0; c < int'(NUM_CH); c++) push(c, 8'd2);
    refresh();
    reset = 1'b0;
    #1 chk("init_latch_nopop", 64'(len_pop), 64'h0);
    tick();
    chk("init_pop_all", 64'(len_pop), 64'hF);
    tick();
    chk("init_pop_clear", 64'(len_pop), 64'h0);
    chk("init_busy", 64'(ch_busy), 64'hF);
    slot_valid = 4'b0100;
    tick();
    slot_valid = '0;
    chk("init_rowid_ch2", 64'(row_id_out), 64'h0002_0000);

    // Zero-bubble refill on ch0
    start_seg(9'd8);
    push(0, 8'd1); push(0, 8'd3);
    push(1, 8'd5); push(2, 8'd5); push(3, 8'd5);
    refresh();
    reset = 1'b0;
    tick();
    chk("zb_pop_all", 64'(len_pop), 64'hF);
    tick();
    slot_valid = 4'b0001;
    #1 chk("zb_refill_pop", 64'(len_pop), 64'h1);
    tick();
    chk("zb_id0", 64'(row_id_out), 64'h0);
    chk("zb_no_pop", 64'(len_pop), 64'h0);
    tick();
    chk("zb_id1", 64'(row_id_out), 64'h4);
    tick();
    chk("zb_id2", 64'(row_id_out), 64'h4);
    tick();
    chk("zb_id3", 64'(row_id_out), 64'h4);
    slot_valid = '0;
    chk("zb_busy_need", 64'(ch_busy), 64'hE);

    // Empty row on ch1
    start_seg(9'd8);
    push(0, 8'd3); push(1, 8'd0); push(1, 8'd2);
    push(2, 8'd3); push(3, 8'd3);
    refresh();
    reset = 1'b0;
    tick();
    chk("er_pop_all", 64'(len_pop), 64'hF);
    tick();
    chk("er_regrant_pop", 64'(len_pop), 64'h2);
    chk("er_busy_need", 64'(ch_busy), 64'hD);
    tick();
    chk("er_busy_run", 64'(ch_busy), 64'hF);
    slot_valid = 4'b0010;
    tick();
    chk("er_id0", 64'(row_id_out), 64'h0000_0400);
    tick();
    chk("er_id1", 64'(row_id_out), 64'h0000_0400);
    slot_valid = '0;
    chk("er_busy_end", 64'(ch_busy), 64'hD);

    // Simultaneous refills past the row limit
    start_seg(9'd6);
    push(0, 8'd1); push(0, 8'd2);
    push(1, 8'd1); push(1, 8'd1);
    push(2, 8'd1); push(2, 8'd5);
    push(3, 8'd1); push(3, 8'd5);
    refresh();
    reset = 1'b0;
    tick();
    chk("lim_pop_all", 64'(len_pop), 64'hF);
    tick();
    slot_valid = 4'b1111;
    #1 chk("lim_pop_two", 64'(len_pop), 64'h3);
    tick();
    chk("lim_id_a", 64'(row_id_out), 64'h0302_0100);
    chk("lim_busy_a", 64'(ch_busy), 64'h3);
    chk("lim_done_a", 64'(done), 64'h0);
    slot_valid = 4'b0011;
    tick();
    chk("lim_id_b", 64'(row_id_out), 64'h0302_0504);
    chk("lim_busy_b", 64'(ch_busy), 64'h1);
    chk("lim_done_b", 64'(done), 64'h0);
    slot_valid = 4'b0001;
    tick();
    chk("lim_done_c", 64'(done), 64'h1);
    chk("lim_busy_c", 64'(ch_busy), 64'h0);
    chk("lim_id_c", 64'(row_id_out), 64'h0302_0504);
    slot_valid = 4'b0100;
    tick();
    slot_valid = '0;
    chk("lim_fin_proto", 64'(proto_err), 64'h1);
    chk("lim_fin_id_hold", 64'(row_id_out), 64'h0302_0504);
    chk("lim_done_sticky", 64'(done), 64'h1);

    // Protocol error in NEED, then reset with rows in flight
    start_seg(9'd8);
    push(0, 8'd4); push(1, 8'd4); push(2, 8'd4);
    refresh();
    reset = 1'b0;
    tick();
    chk("pe_pop", 64'(len_pop), 64'h7);
    tick();
    chk("pe_clean", 64'(proto_err), 64'h0);
    slot_valid = 4'b1111;
    tick();
    chk("pe_set", 64'(proto_err), 64'h1);
    chk("pe_id", 64'(row_id_out), 64'h0002_0100);
    slot_valid = 4'b0111;
    tick();
    chk("pe_sticky", 64'(proto_err), 64'h1);
    chk("pe_id_hold3", 64'(row_id_out), 64'h0002_0100);
    start_seg(9'd8);
    chk("mr_rowid", 64'(row_id_out), 64'h0);
    chk("mr_busy", 64'(ch_busy), 64'h0);
    chk("mr_proto", 64'(proto_err), 64'h0);
    chk("mr_done", 64'(done), 64'h0);
    push(0, 8'd2); push(1, 8'd2);
    refresh();
    reset = 1'b0;
    #1 chk("mr_latch_nopop", 64'(len_pop), 64'h0);
    tick();
    chk("mr_regrant_pop", 64'(len_pop), 64'h3);
    tick();
    chk("mr_busy_run", 64'(ch_busy), 64'h3);
    slot_valid = 4'b0011;
    tick();
    slot_valid = '0;
    chk("mr_ids_from0", 64'(row_id_out), 64'h0000_0100);

    // Zero rows: done two cycles after reset release
    start_seg(9'd0);
    reset = 1'b0;
    chk("z_done_a", 64'(done), 64'h0);
    tick();
    chk("z_done_b", 64'(done), 64'h0);
    tick();
    chk("z_done_c", 64'(done), 64'h1);
    chk("z_busy", 64'(ch_busy), 64'h0);
    chk("z_proto", 64'(proto_err), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
